prog_moore_fsm: RTL and testbench

- Table-driven, run-time programmable Moore state machine. Generalises the team's fixed 3-state controllers to NUM_STATES states, an IN_W-bit input symbol and an OUT_W-bit per-state output.
- The transition/output table is written through a config port, so one instance replaces per-configuration hand-coded FSMs.
- Advances only on a step qualifier. Provides a synchronous start-state load, a step counter and sticky error flags.

---
 rtl/prog_moore_pkg.sv | 13 +
 rtl/prog_moore_table.sv | 38 +++
 rtl/prog_moore_fsm.sv | 63 ++++++
 tb/tb_prog_moore_fsm.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_moore_pkg.sv
// prog_moore_pkg: shared constants and width helper for the programmable Moore FSM.
package prog_moore_pkg;
  localparam int ERR_BAD_NEXT = 0;
  localparam int ERR_BAD_START = 1;
  localparam int ERR_BAD_CFG_STATE = 2;
  localparam int DEF_NUM_STATES = 8;
  localparam int DEF_IN_W = 2;
  localparam int DEF_OUT_W = 1;
  localparam int DEF_CNT_W = 16;
  function automatic int state_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prog_moore_table.sv
// prog_moore_table: flop-based next-state and output tables with one write port each
// and combinational lookups for the current state.
module prog_moore_table #(
  parameter int NUM_STATES = 8,
  parameter int IN_W = 2,
  parameter int OUT_W = 1,
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next_we,
  input  logic [STATE_W-1:0] next_row,
  input  logic [IN_W-1:0]    next_col,
  input  logic [STATE_W-1:0] next_val,
  input  logic               out_we,
  input  logic [STATE_W-1:0] out_row,
  input  logic [OUT_W-1:0]   out_val,
  input  logic [STATE_W-1:0] rd_state,
  input  logic [IN_W-1:0]    rd_sym,
  output logic [STATE_W-1:0] rd_next,
  output logic [OUT_W-1:0]   rd_out
);
  logic [STATE_W-1:0] next_tab [NUM_STATES][2**IN_W];
  logic [OUT_W-1:0]   out_tab  [NUM_STATES];
  // Reset leaves every state as a self-loop with a zero output.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        out_tab[s] <= '0;
        for (int k = 0; k < 2**IN_W; k++) next_tab[s][k] <= STATE_W'(s);
      end
    end else begin
      if (next_we) next_tab[next_row][next_col] <= next_val;
      if (out_we) out_tab[out_row] <= out_val;
    end
  assign rd_next = next_tab[rd_state][rd_sym];
  assign rd_out = out_tab[rd_state];
endmodule

// File: rtl/prog_moore_fsm.sv
// prog_moore_fsm: run-time programmable Moore FSM with step qualifier, start-state
// load, saturating step counter and sticky range-check error flags.
module prog_moore_fsm import prog_moore_pkg::*; #(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int STATE_W = state_width(NUM_STATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    sw_in,
  input  logic               step,
  input  logic               load,
  input  logic [STATE_W-1:0] start_state,
  input  logic               cfg_we,
  input  logic               cfg_out_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [IN_W-1:0]    cfg_sym,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  input  logic               err_clr,
  output logic [STATE_W-1:0] state,
  output logic [OUT_W-1:0]   out,
  output logic [CNT_W-1:0]   step_count,
  output logic [2:0]         err
);
  localparam logic [STATE_W:0] LIMIT = (STATE_W+1)'(NUM_STATES);
  logic [STATE_W-1:0] state_nx, tab_next;
  logic start_ok, cfg_state_ok, cfg_next_ok, accept, next_we, out_we;
  logic [2:0] err_set;
  assign start_ok = {1'b0, start_state} < LIMIT;
  assign cfg_state_ok = {1'b0, cfg_state} < LIMIT;
  assign cfg_next_ok = {1'b0, cfg_next} < LIMIT;
  assign accept = step & ~load;
  assign next_we = cfg_we & cfg_state_ok & cfg_next_ok;
  assign out_we = cfg_out_we & cfg_state_ok;
  prog_moore_table #(
    .NUM_STATES(NUM_STATES), .IN_W(IN_W), .OUT_W(OUT_W), .STATE_W(STATE_W)
  ) u_table (
    .clk(clk), .reset(reset),
    .next_we(next_we), .next_row(cfg_state), .next_col(cfg_sym), .next_val(cfg_next),
    .out_we(out_we), .out_row(cfg_state), .out_val(cfg_out),
    .rd_state(state), .rd_sym(sw_in), .rd_next(tab_next), .rd_out(out)
  );
  always_comb begin
    state_nx = load ? (start_ok ? start_state : state) : (step ? tab_next : state);
    err_set = '0;
    err_set[ERR_BAD_START] = load & ~start_ok;
    err_set[ERR_BAD_CFG_STATE] = (cfg_we | cfg_out_we) & ~cfg_state_ok;
    err_set[ERR_BAD_NEXT] = cfg_we & cfg_state_ok & ~cfg_next_ok;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= '0;
      step_count <= '0;
      err <= '0;
    end else begin
      state <= state_nx;
      if (accept && step_count != '1) step_count <= step_count + CNT_W'(1);
      err <= (err_clr ? 3'b000 : err) | err_set;
    end
endmodule

// File: tb/tb_prog_moore_fsm.sv
// tb_prog_moore_fsm: directed and randomized checks of prog_moore_fsm against a
// table-level behavioural model.
module tb_prog_moore_fsm;
  localparam int NS = 6, IW = 2, OW = 1, CW = 16, SW = 3;
  logic clk = 0, reset = 1, step = 0, load = 0, cfg_we = 0, cfg_out_we = 0, err_clr = 0;
  logic [IW-1:0] sw_in = 0, cfg_sym = 0;
  logic [SW-1:0] start_state = 0, cfg_state = 0, cfg_next = 0;
  logic [OW-1:0] cfg_out = 0;
  logic [SW-1:0] state, state8;
  logic [OW-1:0] out, out8;
  logic [CW-1:0] step_count;
  logic [2:0] step_count8, err, err8;
  int n_tests = 0, n_fail = 0;
  int m_next [NS][4];
  int m_out [NS];
  int m_state, m_cnt, m_cnt8;
  logic [2:0] m_err;

  always #5 clk = ~clk;

  prog_moore_fsm #(.NUM_STATES(NS), .IN_W(IW), .OUT_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .step(step), .load(load), .start_state(start_state),
    .cfg_we(cfg_we), .cfg_out_we(cfg_out_we), .cfg_state(cfg_state), .cfg_sym(cfg_sym),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .err_clr(err_clr),
    .state(state), .out(out), .step_count(step_count), .err(err));

  prog_moore_fsm #(.NUM_STATES(8), .IN_W(IW), .OUT_W(OW), .CNT_W(3)) dut8 (
    .clk(clk), .reset(reset), .sw_in(sw_in), .step(step), .load(load), .start_state(start_state),
    .cfg_we(cfg_we), .cfg_out_we(cfg_out_we), .cfg_state(cfg_state), .cfg_sym(cfg_sym),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .err_clr(err_clr),
    .state(state8), .out(out8), .step_count(step_count8), .err(err8));

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_out[s] = 0;
      for (int k = 0; k < 4; k++) m_next[s][k] = s;
    end
    m_state = 0; m_cnt = 0; m_cnt8 = 0; m_err = 0;
  endtask

  // One clock of the abstract machine: the step reads the table before any write lands.
  task automatic model_clk();
    int ns;
    logic [2:0] es;
    ns = m_state;
    es = 0;
    if (load) begin
      if (int'(start_state) < NS) ns = int'(start_state);
      else es[1] = 1;
    end else if (step) ns = m_next[m_state][sw_in];
    if (step && !load) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt8 < 7) m_cnt8++;
    end
    if (cfg_we || cfg_out_we) begin
      if (int'(cfg_state) >= NS) es[2] = 1;
      else begin
        if (cfg_we) begin
          if (int'(cfg_next) < NS) m_next[cfg_state][cfg_sym] = int'(cfg_next);
          else es[0] = 1;
        end
        if (cfg_out_we) m_out[cfg_state] = int'(cfg_out);
      end
    end
    m_err = (err_clr ? 3'b000 : m_err) | es;
    m_state = ns;
  endtask

  task automatic idle();
    step = 0; load = 0; cfg_we = 0; cfg_out_we = 0; err_clr = 0;
  endtask

  task automatic tick();
    model_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic wr_next(input int s, input int k, input int n);
    cfg_we = 1; cfg_state = SW'(s); cfg_sym = IW'(k); cfg_next = SW'(n);
    tick();
    cfg_we = 0;
  endtask

  task automatic wr_out(input int s, input int o);
    cfg_out_we = 1; cfg_state = SW'(s); cfg_out = OW'(o);
    tick();
    cfg_out_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (state !== 0 || out !== 0 || step_count !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d out=%0d cnt=%0d err=%b want 0 0 0 000", state, out, step_count, err);
    end
    step = 1; sw_in = 3;
    repeat (5) tick();
    step = 0;
    n_tests++;
    if (state !== 0 || out !== 0 || step_count !== 5 || err !== 0) begin
      n_fail++;
      $display("FAIL reset_selfloop: got st=%0d out=%0d cnt=%0d err=%b want 0 0 5 000", state, out, step_count, err);
    end
  endtask

  task automatic test_program();
    int syms [5] = '{2, 0, 2, 1, 0};
    int exp_st [5] = '{1, 1, 2, 0, 1};
    int exp_out [5] = '{0, 0, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 4; k++) wr_next(0, k, 1);
    wr_next(1, 0, 1); wr_next(1, 1, 0); wr_next(1, 2, 2); wr_next(1, 3, 2);
    wr_next(2, 0, 2); wr_next(2, 1, 0); wr_next(2, 2, 2); wr_next(2, 3, 0);
    wr_out(2, 1);
    for (int i = 0; i < 5; i++) begin
      step = 1; sw_in = IW'(syms[i]);
      tick();
      n_tests++;
      if (state !== SW'(exp_st[i]) || out !== OW'(exp_out[i])) begin
        n_fail++;
        $display("FAIL program_seq[%0d]: got st=%0d out=%0d want st=%0d out=%0d", i, state, out, exp_st[i], exp_out[i]);
      end
    end
    step = 0;
    n_tests++;
    if (step_count !== 5) begin
      n_fail++;
      $display("FAIL program_count: got %0d want 5", step_count);
    end
  endtask

  task automatic test_gating();
    for (int i = 0; i < 4; i++) begin
      sw_in = IW'(i);
      tick();
    end
    n_tests++;
    if (state !== 1) begin
      n_fail++;
      $display("FAIL step_gate: got st=%0d want 1", state);
    end
    load = 1; step = 1; start_state = 2;
    tick();
    n_tests++;
    if (state !== 2 || out !== 1 || step_count !== 5) begin
      n_fail++;
      $display("FAIL load_priority: got st=%0d out=%0d cnt=%0d want 2 1 5", state, out, step_count);
    end
    step = 0; start_state = 7;
    tick();
    load = 0;
    n_tests++;
    if (state !== 2 || err !== 3'b010) begin
      n_fail++;
      $display("FAIL bad_start: got st=%0d err=%b want 2 010", state, err);
    end
  endtask

  task automatic test_cfg_err();
    err_clr = 1; tick(); err_clr = 0;
    n_tests++;
    if (err !== 0) begin n_fail++; $display("FAIL err_clr: got %b want 000", err); end
    wr_next(2, 0, 6);
    n_tests++;
    if (err !== 3'b001) begin n_fail++; $display("FAIL bad_next: got %b want 001", err); end
    wr_out(6, 1);
    n_tests++;
    if (err !== 3'b101) begin n_fail++; $display("FAIL bad_cfg_state: got %b want 101", err); end
    err_clr = 1; tick(); err_clr = 0;
    err_clr = 1; cfg_we = 1; cfg_state = 7; cfg_next = 7; cfg_sym = 0;
    tick();
    idle();
    n_tests++;
    if (err !== 3'b100) begin n_fail++; $display("FAIL clr_vs_set: got %b want 100", err); end
    step = 1; sw_in = 0;
    tick();
    step = 0;
    n_tests++;
    if (state !== 2 || out !== 1) begin
      n_fail++;
      $display("FAIL entry_kept: got st=%0d out=%0d want 2 1", state, out);
    end
  endtask

  task automatic test_collision();
    load = 1; start_state = 1; tick(); load = 0;
    step = 1; sw_in = 0; cfg_we = 1; cfg_state = 1; cfg_sym = 0; cfg_next = 2;
    tick();
    cfg_we = 0;
    n_tests++;
    if (state !== 1) begin n_fail++; $display("FAIL collision_old: got st=%0d want 1", state); end
    tick();
    step = 0;
    n_tests++;
    if (state !== 2) begin n_fail++; $display("FAIL collision_new: got st=%0d want 2", state); end
  endtask

  task automatic test_saturation();
    do_reset();
    step = 1;
    repeat (9) tick();
    step = 0;
    n_tests++;
    if (step_count8 !== 3'd7 || step_count !== 9) begin
      n_fail++;
      $display("FAIL saturate: got cnt3=%0d cnt16=%0d want 7 9", step_count8, step_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_next(0, 0, 3);
    wr_out(3, 1);
    step = 1; sw_in = 0; tick(); step = 0;
    n_tests++;
    if (state !== 3 || out !== 1) begin
      n_fail++;
      $display("FAIL pre_reset: got st=%0d out=%0d want 3 1", state, out);
    end
    #2 reset = 1;
    #1;
    n_tests++;
    if (state !== 0 || out !== 0 || step_count !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d out=%0d cnt=%0d err=%b want 0 0 0 000", state, out, step_count, err);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    load = 1; start_state = 3; tick(); load = 0;
    step = 1; sw_in = 0; tick(); step = 0;
    n_tests++;
    if (state !== 3 || out !== 0) begin
      n_fail++;
      $display("FAIL table_reverted: got st=%0d out=%0d want 3 0", state, out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 7) == 0);
      start_state = SW'($urandom_range(0, 7));
      sw_in = IW'($urandom_range(0, 3));
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_out_we = ($urandom_range(0, 5) == 0);
      cfg_state = SW'($urandom_range(0, 7));
      cfg_sym = IW'($urandom_range(0, 3));
      cfg_next = SW'($urandom_range(0, 7));
      cfg_out = OW'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 9) == 0);
      tick();
      n_tests++;
      if (state !== SW'(m_state) || out !== OW'(m_out[m_state]) || step_count !== CW'(m_cnt)
          || err !== m_err || step_count8 !== 3'(m_cnt8)) begin
        n_fail++;
        $display("FAIL random[%0d]: got st=%0d out=%0d cnt=%0d cnt3=%0d err=%b want st=%0d out=%0d cnt=%0d cnt3=%0d err=%b",
                 c, state, out, step_count, step_count8, err, m_state, m_out[m_state], m_cnt, m_cnt8, m_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_program();
    test_gating();
    test_cfg_err();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
